// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet arbiter feeding the write side of an async FIFO.
// A channel owns the FIFO from its grant until the beat carrying ch_last_i is accepted,
// so packets are never interleaved. Every FIFO word is {channel id, last, data}, with
// the id in the MSBs. The write to the FIFO is registered, giving one cycle of latency.
//
// Ports:
//   wr_clk_i          write-domain clock
//   wr_rst_n_i        asynchronous active-low reset
//   ch_valid_i        per-channel beat valid
//   ch_data_i         per-channel payload, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ch_last_i         per-channel end-of-packet marker
//   ch_ready_o        per-channel beat accept (only the granted channel, only in XFER)
//   fifo_prog_full_i  FIFO programmable-full; blocks new grants and beat acceptance
//   fifo_full_i       FIFO full; blocks beat acceptance
//   fifo_wr_en_o      registered FIFO write enable
//   fifo_din_o        registered FIFO write word
//   grant_o           currently granted channel
//   busy_o            high while a packet is being transferred
//
// The integrator must set PROG_FULL_NUM <= FIFO_DEEP-2. ch_ready_o is computed from the
// flags alone and never from fifo_wr_en_o, so one registered write can still be in flight
// when prog_full rises. That margin keeps the in-flight write from overflowing the FIFO.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned FW        = DATA_WIDTH + CH_W + 1
) (
  input  logic                         wr_clk_i,
  input  logic                         wr_rst_n_i,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]            ch_last_i,
  output logic [NUM_CH-1:0]            ch_ready_o,
  input  logic                         fifo_prog_full_i,
  input  logic                         fifo_full_i,
  output logic                         fifo_wr_en_o,
  output logic [FW-1:0]                fifo_din_o,
  output logic [CH_W-1:0]              grant_o,
  output logic                         busy_o
);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  wr_en_q, wr_en_d;
  logic [FW-1:0]         din_q, din_d;

  logic [CH_W-1:0]       pick;
  logic                  pick_vld;
  int unsigned           idx;
  logic [CH_W-1:0]       idx_w;

  logic                  beat_ok;
  logic                  cur_valid;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  accept;

  // First valid channel at or above rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx   = (32'(rr_ptr_q) + i) % NUM_CH;
      idx_w = CH_W'(idx);
      if (!pick_vld && ch_valid_i[idx_w]) begin
        pick     = idx_w;
        pick_vld = 1'b1;
      end
    end
  end

  assign beat_ok   = ~fifo_prog_full_i & ~fifo_full_i;
  assign cur_valid = ch_valid_i[grant_q];
  assign cur_last  = ch_last_i[grant_q];
  assign cur_data  = ch_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign accept    = (state_q == StXfer) & cur_valid & beat_ok;

  always_comb begin
    ch_ready_o = '0;
    if (state_q == StXfer) begin
      ch_ready_o[grant_q] = beat_ok;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wr_en_d  = 1'b0;
    din_d    = din_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld && !fifo_prog_full_i) begin
          grant_d = pick;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (accept) begin
          wr_en_d = 1'b1;
          din_d   = {grant_q, cur_last, cur_data};
          if (cur_last) begin
            rr_ptr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
            state_d  = StIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
    if (!wr_rst_n_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wr_en_q  <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= wr_en_d;
      din_q    <= din_d;
    end
  end

  assign fifo_wr_en_o = wr_en_q;
  assign fifo_din_o   = din_q;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q == StXfer);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_CH=4, DATA_WIDTH=8).
// Directed packets are queued per channel. The expected FIFO words are pushed into exp_q
// in hand-computed order. A monitor pops exp_q and compares on every fifo_wr_en_o.
module tb_fifo_wr_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CW  = 2;
  localparam int FW  = DW + CW + 1;

  logic              wr_clk_i = 1'b0;
  logic              wr_rst_n_i = 1'b1;
  logic [NCH-1:0]    ch_valid_i = '0;
  logic [NCH*DW-1:0] ch_data_i = '0;
  logic [NCH-1:0]    ch_last_i = '0;
  logic [NCH-1:0]    ch_ready_o;
  logic              fifo_prog_full_i = 1'b0;
  logic              fifo_full_i = 1'b0;
  logic              fifo_wr_en_o;
  logic [FW-1:0]     fifo_din_o;
  logic [CW-1:0]     grant_o;
  logic              busy_o;

  always #5 wr_clk_i = ~wr_clk_i;

  fifo_wr_arbiter #(
    .NUM_CH    (NCH),
    .DATA_WIDTH(DW)
  ) dut (
    .wr_clk_i        (wr_clk_i),
    .wr_rst_n_i      (wr_rst_n_i),
    .ch_valid_i      (ch_valid_i),
    .ch_data_i       (ch_data_i),
    .ch_last_i       (ch_last_i),
    .ch_ready_o      (ch_ready_o),
    .fifo_prog_full_i(fifo_prog_full_i),
    .fifo_full_i     (fifo_full_i),
    .fifo_wr_en_o    (fifo_wr_en_o),
    .fifo_din_o      (fifo_din_o),
    .grant_o         (grant_o),
    .busy_o          (busy_o)
  );

  logic [FW-1:0] exp_q[$];
  logic [8:0]    beats[NCH][$];  // {last, data} still to be offered per channel
  int            n_pass  = 0;
  int            n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [FW-1:0] word(input int ch, input bit last, input logic [7:0] d);
    return {CW'(ch), last, d};
  endfunction

  function automatic bit all_empty();
    for (int k = 0; k < NCH; k++) if (beats[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Scoreboard monitor: every FIFO write must match the head of exp_q.
  always @(negedge wr_clk_i) begin
    if (wr_rst_n_i === 1'b1 && fifo_wr_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got 0x%0h, expected no write at %0t",
                 fifo_din_o, $time);
      end else begin
        check("fifo_din", 32'(fifo_din_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive();
    for (int k = 0; k < NCH; k++) begin
      if (beats[k].size() > 0) begin
        ch_valid_i[k]           = 1'b1;
        ch_last_i[k]            = beats[k][0][8];
        ch_data_i[k*DW +: DW]   = beats[k][0][7:0];
      end else begin
        ch_valid_i[k]           = 1'b0;
        ch_last_i[k]            = 1'b0;
        ch_data_i[k*DW +: DW]   = '0;
      end
    end
  endtask

  // One clock: sample handshakes at negedge, retire accepted beats after the posedge.
  task automatic tick();
    bit acc[NCH];
    @(negedge wr_clk_i);
    for (int k = 0; k < NCH; k++) acc[k] = ch_valid_i[k] & ch_ready_o[k];
    @(posedge wr_clk_i);
    #1;
    for (int k = 0; k < NCH; k++) if (acc[k]) void'(beats[k].pop_front());
    drive();
  endtask

  task automatic run_until_idle(input int max, input string tag);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < max) begin
      tick();
      n++;
      done = all_empty() && (busy_o == 1'b0);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    @(negedge wr_clk_i);
    #1;
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_dut();
    for (int k = 0; k < NCH; k++) beats[k].delete();
    exp_q.delete();
    fifo_prog_full_i = 1'b0;
    fifo_full_i      = 1'b0;
    drive();
    #1 wr_rst_n_i = 1'b0;
    #1 check("reset_outputs", 32'({ch_ready_o, fifo_wr_en_o, fifo_din_o, grant_o, busy_o}), 0);
    @(posedge wr_clk_i);
    @(posedge wr_clk_i);
    #1 wr_rst_n_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g[5] = '{0, 1, 2, 3, 0};
    int n;

    // T1: ch0 3-beat packet, FIFO empty.
    reset_dut();
    beats[0].push_back({1'b0, 8'h11});
    beats[0].push_back({1'b0, 8'h22});
    beats[0].push_back({1'b1, 8'h33});
    exp_q.push_back(word(0, 0, 8'h11));
    exp_q.push_back(word(0, 0, 8'h22));
    exp_q.push_back(word(0, 1, 8'h33));
    drive();
    run_until_idle(20, "t1");
    check("t1_idle", 32'({busy_o, ch_ready_o}), 0);

    // T2: all channels valid with 1-beat packets -> 0,1,2,3,0, one idle cycle between.
    reset_dut();
    beats[0].push_back({1'b1, 8'hA0});
    beats[1].push_back({1'b1, 8'hA1});
    beats[2].push_back({1'b1, 8'hA2});
    beats[3].push_back({1'b1, 8'hA3});
    beats[0].push_back({1'b1, 8'hB0});
    exp_q.push_back(word(0, 1, 8'hA0));
    exp_q.push_back(word(1, 1, 8'hA1));
    exp_q.push_back(word(2, 1, 8'hA2));
    exp_q.push_back(word(3, 1, 8'hA3));
    exp_q.push_back(word(0, 1, 8'hB0));
    drive();
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j % 2 == 0) check("t2_grant", 32'({busy_o, grant_o}), 32'({1'b1, CW'(g[j/2])}));
      else            check("t2_idle_gap", 32'(busy_o), 0);
    end
    run_until_idle(5, "t2");

    // T3: ch2 packet in progress; ch1 must wait, then wins after wrap (ch3 idle).
    reset_dut();
    beats[2].push_back({1'b0, 8'hC1});
    beats[2].push_back({1'b0, 8'hC2});
    beats[2].push_back({1'b1, 8'hC3});
    exp_q.push_back(word(2, 0, 8'hC1));
    exp_q.push_back(word(2, 0, 8'hC2));
    exp_q.push_back(word(2, 1, 8'hC3));
    exp_q.push_back(word(1, 1, 8'h55));
    drive();
    tick();
    check("t3_grant2", 32'({busy_o, grant_o}), 32'({1'b1, 2'd2}));
    beats[1].push_back({1'b1, 8'h55});
    drive();
    n = 0;
    while (beats[2].size() > 0 && n < 20) begin
      #1 check("t3_ch1_blocked", 32'(ch_ready_o[1]), 0);
      tick();
      n++;
    end
    tick();
    check("t3_grant1", 32'({busy_o, grant_o}), 32'({1'b1, 2'd1}));
    run_until_idle(10, "t3");

    // T4: prog_full high 5 cycles mid-packet.
    reset_dut();
    beats[0].push_back({1'b0, 8'h41});
    beats[0].push_back({1'b0, 8'h42});
    beats[0].push_back({1'b0, 8'h43});
    beats[0].push_back({1'b1, 8'h44});
    exp_q.push_back(word(0, 0, 8'h41));
    exp_q.push_back(word(0, 0, 8'h42));
    exp_q.push_back(word(0, 0, 8'h43));
    exp_q.push_back(word(0, 1, 8'h44));
    drive();
    n = 0;
    while (beats[0].size() != 3 && n < 10) begin
      tick();
      n++;
    end
    fifo_prog_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_stalled", 32'({busy_o, ch_ready_o, fifo_wr_en_o}), 32'({1'b1, 4'b0, 1'b0}));
    end
    fifo_prog_full_i = 1'b0;
    run_until_idle(20, "t4");

    // T5: full high with prog_full low -> granted but no writes.
    reset_dut();
    fifo_full_i = 1'b1;
    beats[3].push_back({1'b0, 8'hD1});
    beats[3].push_back({1'b1, 8'hD2});
    exp_q.push_back(word(3, 0, 8'hD1));
    exp_q.push_back(word(3, 1, 8'hD2));
    drive();
    tick();
    check("t5_grant3", 32'({busy_o, grant_o}), 32'({1'b1, 2'd3}));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_full_blocked", 32'({ch_ready_o, fifo_wr_en_o}), 0);
    end
    fifo_full_i = 1'b0;
    run_until_idle(20, "t5");

    // T6: reset during beat 2 of a 4-beat ch1 packet; remainder discarded.
    reset_dut();
    beats[1].push_back({1'b0, 8'h61});
    beats[1].push_back({1'b0, 8'h62});
    beats[1].push_back({1'b0, 8'h63});
    beats[1].push_back({1'b1, 8'h64});
    exp_q.push_back(word(1, 0, 8'h61));
    drive();
    n = 0;
    while (beats[1].size() != 3 && n < 10) begin
      tick();
      n++;
    end
    @(negedge wr_clk_i);
    #1 wr_rst_n_i = 1'b0;
    for (int k = 0; k < NCH; k++) beats[k].delete();
    beats[2].push_back({1'b1, 8'h77});
    beats[3].push_back({1'b1, 8'h88});
    drive();
    #1 check("t6_reset_outputs",
             32'({ch_ready_o, fifo_wr_en_o, fifo_din_o, grant_o, busy_o}), 0);
    check("t6_first_word_seen", 32'(exp_q.size()), 0);
    exp_q.push_back(word(2, 1, 8'h77));
    exp_q.push_back(word(3, 1, 8'h88));
    @(posedge wr_clk_i);
    #1 wr_rst_n_i = 1'b1;
    tick();
    check("t6_grant2", 32'({busy_o, grant_o}), 32'({1'b1, 2'd2}));
    run_until_idle(10, "t6");

    check("final_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
